// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
// The optional 2-of-3 majority sampling is selected with the
// UART_RX_MAJORITY_EN macro (see uart_rx_sampler / uart_rx_cfg).
package uart_pkg;

   // Receiver FSM states. The parity state carries a suffix so it does not
   // collide with the PARITY parameter of the receiver.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY_BIT,
      STOP
   } state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Clock cycles per bit period.
   function automatic int baud_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Register width needed to count 0..n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the UART receiver: 2-flop synchroniser for the asynchronous
// line, a registered copy for falling-edge detection and the bit decision.
// With UART_RX_MAJORITY_EN defined the bit decision is a 2-of-3 vote over the
// current and two previous synchronised samples; otherwise it is the current
// synchronised sample.
module uart_rx_sampler (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   output logic fall_edge,
   output logic bit_v
);

   logic sync1;
   logic rx_s;
   logic rx_prev;

   // Synchroniser and edge-detect history; reset high so an idle line never
   // looks like a start bit right after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   assign fall_edge = rx_prev & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
   logic rx_prev2;

   // One more sample of history so the vote spans three consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_prev2 <= 1'b1;
      end else begin
         rx_prev2 <= rx_prev;
      end
   end

   assign bit_v = (rx_s & rx_prev) | (rx_s & rx_prev2) | (rx_prev & rx_prev2);
`else
   assign bit_v = rx_s;
`endif

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver (data width, parity, stop bits, baud).
// Each received word is presented on o_data together with its framing and
// parity flags and a one-cycle o_valid strobe. Error frames still deliver.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority bit decisions, which
// moves every decision (and o_valid) one cycle later.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 48000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_busy
);

   localparam int BAUD_CLK = baud_div(CLK_HZ, BAUD);
   localparam int CW       = cnt_width(BAUD_CLK);
   localparam int IW       = cnt_width(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
   // The vote needs the sample after the nominal point, so decide one later.
   localparam int DECIDE_OFS = 1;
`else
   localparam int DECIDE_OFS = 0;
`endif

   localparam logic [CW-1:0] TICK      = CW'(BAUD_CLK - 1);
   localparam logic [CW-1:0] HALF_PT   = CW'((BAUD_CLK - 1) / 2 + DECIDE_OFS);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
   localparam logic          EXP_PAR   = (PARITY == PARITY_ODD);
   localparam logic          LAST_STOP = (STOP_BITS == 2);
   localparam logic          HAS_PAR   = (PARITY != PARITY_NONE);

   logic                 fall_edge;
   logic                 bit_v;
   state_t               state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc;
   logic                 par_err_acc;
   logic                 frame_acc;

   uart_rx_sampler u_sampler (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .rx        (i_rx),
      .fall_edge (fall_edge),
      .bit_v     (bit_v)
   );

   assign o_busy = (state != IDLE);

   // Frame FSM: baud counting, bit assembly, error accumulation and the
   // registered word/flag/strobe outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         stop_idx     <= 1'b0;
         shreg        <= '0;
         par_acc      <= 1'b0;
         par_err_acc  <= 1'b0;
         frame_acc    <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_parity_err <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (fall_edge) begin
                  state <= START;
                  cnt   <= '0;
               end
            end

            START: begin
               if (cnt == HALF_PT) begin
                  cnt <= '0;
                  if (!bit_v) begin
                     state       <= DATA;
                     idx         <= '0;
                     par_acc     <= 1'b0;
                     par_err_acc <= 1'b0;
                     frame_acc   <= 1'b0;
                  end else begin
                     // Line back high at mid start bit: treat as a glitch.
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            DATA: begin
               if (cnt == TICK) begin
                  cnt     <= '0;
                  shreg   <= {bit_v, shreg[DATA_BITS-1:1]};
                  par_acc <= par_acc ^ bit_v;
                  if (idx == LAST_BIT) begin
                     state    <= HAS_PAR ? PARITY_BIT : STOP;
                     stop_idx <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            PARITY_BIT: begin
               if (cnt == TICK) begin
                  cnt         <= '0;
                  par_err_acc <= ((par_acc ^ bit_v) != EXP_PAR);
                  state       <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            STOP: begin
               if (cnt == TICK) begin
                  cnt <= '0;
                  if (stop_idx == LAST_STOP) begin
                     // Finish at mid stop bit so a following start edge
                     // with no idle gap is still caught.
                     o_data       <= shreg;
                     o_frame_err  <= frame_acc | ~bit_v;
                     o_parity_err <= par_err_acc;
                     o_valid      <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     frame_acc <= frame_acc | ~bit_v;
                     stop_idx  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) at
// 48 MHz / 115200 baud (416 cycles per bit) driven from one linear sequence.
module tb_uart_rx_cfg;

   localparam int BC   = 416;
   localparam int HALF = (BC - 1) / 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT signals ----------------
   logic       rx_a, rx_p, rx_s2;
   logic [7:0] data_a;
   logic       valid_a, fe_a, pe_a, busy_a;
   logic [6:0] data_p;
   logic       valid_p, fe_p, pe_p, busy_p;
   logic [7:0] data_s;
   logic       valid_s, fe_s, pe_s, busy_s;

   uart_rx_cfg #(.CLK_HZ(48000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_data(data_a), .o_valid(valid_a),
      .o_frame_err(fe_a), .o_parity_err(pe_a), .o_busy(busy_a));

   uart_rx_cfg #(.CLK_HZ(48000000), .BAUD(115200), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_p (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_p), .o_data(data_p), .o_valid(valid_p),
      .o_frame_err(fe_p), .o_parity_err(pe_p), .o_busy(busy_p));

   uart_rx_cfg #(.CLK_HZ(48000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_s (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_s2), .o_data(data_s), .o_valid(valid_s),
      .o_frame_err(fe_s), .o_parity_err(pe_s), .o_busy(busy_s));

   // ---------------- scoreboard ----------------
   // Words are packed as {frame_err, parity_err, data (zero-extended to 9)}.
   logic [10:0] exp_q[$];
   logic [10:0] got_a[$], got_p[$], got_s[$];
   int          total = 0;
   int          bad = 0;
   int          fall_cyc = 0;
   int          lat_a = -1;
   logic        prev_valid_a = 1'b0;
   logic        busy_after_a = 1'bx;

   // Capture every strobe of every receiver, away from the active edge.
   always @(negedge clk) begin
      if (prev_valid_a) busy_after_a = busy_a;
      prev_valid_a = valid_a;
      if (valid_a) begin
         got_a.push_back({fe_a, pe_a, 1'b0, data_a});
         lat_a = cyc - fall_cyc;
      end
      if (valid_p) got_p.push_back({fe_p, pe_p, 2'b00, data_p});
      if (valid_s) got_s.push_back({fe_s, pe_s, 1'b0, data_s});
   end

   function automatic logic [10:0] mk(input logic fe, input logic pe, input logic [8:0] d);
      return {fe, pe, d};
   endfunction

   function automatic int got_size(input int w);
      case (w)
         0:       return got_a.size();
         1:       return got_p.size();
         default: return got_s.size();
      endcase
   endfunction

   function automatic logic [10:0] got_pop(input int w);
      case (w)
         0:       return got_a.pop_front();
         1:       return got_p.pop_front();
         default: return got_s.pop_front();
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic set_rx(input int which, input logic v);
      case (which)
         0:       rx_a = v;
         1:       rx_p = v;
         default: rx_s2 = v;
      endcase
   endtask

   // Drive n bits (bit 0 first), each BC cycles long. With glitch set, the
   // single cycle captured at each bit centre is inverted.
   task automatic send_bits(input int which, input logic [15:0] bits, input int n, input bit glitch);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < BC; j++) begin
            @(negedge clk);
            if (i == 0 && j == 0) fall_cyc = cyc;
            set_rx(which, (glitch && j == HALF + 1) ? ~bits[i] : bits[i]);
         end
      end
   endtask

   task automatic idle(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         set_rx(which, 1'b1);
      end
   endtask

   function automatic logic [15:0] f8n1(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   task automatic expect_word(input int which, input string tag, input int budget);
      logic [10:0] exp_v;
      logic [10:0] obs;
      int k;
      exp_v = exp_q.pop_front();
      obs = 'x;
      k = 0;
      while (got_size(which) == 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (got_size(which) != 0) obs = got_pop(which);
      check(tag, 32'(obs), 32'(exp_v));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int k;
      rx_a = 1'b1;
      rx_p = 1'b1;
      rx_s2 = 1'b1;
      rst_n = 1'b0;
      repeat (5) @(negedge clk);

      // Reset state
      check("rst_data", 32'(data_a), 0);
      check("rst_valid_flags", 32'({valid_a, fe_a, pe_a}), 0);
      check("rst_busy", 32'({busy_a, busy_p, busy_s}), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1 0xA5: word, latency window, busy low after strobe
      exp_q.push_back(mk(1'b0, 1'b0, 9'h0A5));
      send_bits(0, f8n1(8'hA5), 10, 1'b0);
      expect_word(0, "a5_word", 2 * BC);
      check("a5_latency_in_3950_3960", 32'(lat_a >= 3950 && lat_a <= 3960), 1);
      check("a5_busy_after", 32'(busy_after_a), 0);
      idle(0, BC);

      // 100-cycle glitch on idle line
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         rx_a = 1'b0;
         if (i == 50) check("glitch_busy_high", 32'(busy_a), 1);
      end
      @(negedge clk);
      rx_a = 1'b1;
      k = 0;
      while (busy_a && k < 210) begin
         @(negedge clk);
         k++;
      end
      check("glitch_busy_low", 32'(busy_a), 0);
      idle(0, 2 * BC);
      check("glitch_no_valid", got_size(0), 0);

      // Back-to-back 0x00 then 0xFF
      exp_q.push_back(mk(1'b0, 1'b0, 9'h000));
      exp_q.push_back(mk(1'b0, 1'b0, 9'h0FF));
      send_bits(0, f8n1(8'h00), 10, 1'b0);
      send_bits(0, f8n1(8'hFF), 10, 1'b0);
      expect_word(0, "b2b_first", 2 * BC);
      expect_word(0, "b2b_second", 2 * BC);
      idle(0, BC);

      // 7E1: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
      exp_q.push_back(mk(1'b0, 1'b1, 9'h007));
      send_bits(1, {6'b0, 1'b1, 1'b0, 7'h07, 1'b0}, 10, 1'b0);
      expect_word(1, "par_bad", 2 * BC);
      idle(1, 3 * BC);
      check("par_flag_held", 32'(pe_p), 1);
      exp_q.push_back(mk(1'b0, 1'b0, 9'h007));
      send_bits(1, {6'b0, 1'b1, 1'b1, 7'h07, 1'b0}, 10, 1'b0);
      expect_word(1, "par_good", 2 * BC);
      idle(1, BC);

      // 8N2: second stop low, then a clean frame clears the flag
      exp_q.push_back(mk(1'b1, 1'b0, 9'h03C));
      send_bits(2, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, 1'b0);
      expect_word(2, "stop2_low", 2 * BC);
      idle(2, 2 * BC);
      exp_q.push_back(mk(1'b0, 1'b0, 9'h05A));
      send_bits(2, {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11, 1'b0);
      expect_word(2, "stop2_clean", 2 * BC);
      idle(2, BC);

      // Reset during data bit 4 of 0x81, then a full 0x81
      send_bits(0, f8n1(8'h81), 5, 1'b0);
      for (int i = 0; i < HALF; i++) begin
         @(negedge clk);
         rx_a = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b0;
      rx_a = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_data_cleared", 32'(data_a), 0);
      check("midrst_busy", 32'(busy_a), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(0, 2 * BC);
      check("midrst_no_valid", got_size(0), 0);
      exp_q.push_back(mk(1'b0, 1'b0, 9'h081));
      send_bits(0, f8n1(8'h81), 10, 1'b0);
      expect_word(0, "midrst_next", 2 * BC);
      idle(0, BC);

`ifdef UART_RX_MAJORITY_EN
      // Single inverted cycle at every bit centre is outvoted
      exp_q.push_back(mk(1'b0, 1'b0, 9'h081));
      send_bits(0, f8n1(8'h81), 10, 1'b1);
      expect_word(0, "maj_glitch", 2 * BC);
      idle(0, BC);
`endif

      // No stray strobes anywhere
      check("no_extra_pulses", got_size(0) + got_size(1) + got_size(2), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
